// File: rtl/jb_rf_slew_irq.sv
// Per-channel RF slew-rate monitor: a debounced fault detector feeds a sticky status bit,
// a saturating fault counter and a masked, registered interrupt output.
module jb_rf_slew_irq #(
  parameter int NUM_CH = 8,
  parameter int DW     = 16,
  parameter int CNT_W  = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_CH-1:0][DW-1:0]      sample_i,
  input  logic [NUM_CH-1:0]              sample_vld_i,
  input  logic [DW-1:0]                  slew_thresh_i,
  input  logic [3:0]                     debounce_i,
  input  logic [NUM_CH-1:0]              rf_overdrive_mute,
  input  logic [NUM_CH-1:0]              rf_slew_rate_irq_mask,
  input  logic [NUM_CH-1:0]              rf_slew_rate_irq_clr,
  input  logic [NUM_CH-1:0]              rf_slew_fault_clr,
  output logic [NUM_CH-1:0]              rf_slew_rate_irq,
  output logic [NUM_CH-1:0][CNT_W-1:0]   rf_slew_fault_count,
  output logic                           irq_o
);

  logic [3:0] run_target;
  logic       irq_q;
  logic       irq_d;

  assign run_target = (debounce_i == 4'd0) ? 4'd1 : debounce_i;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [DW-1:0]    prev_q;
      logic             prev_vld_q;
      logic             s1_vld_q;
      logic             s1_viol_q;
      logic [3:0]       run_q, run_d;
      logic             evt_q, evt_d;
      logic             st_q, st_d;
      logic [CNT_W-1:0] cnt_q, cnt_d;
      logic [DW:0]      diff;
      logic [DW:0]      mag;
      logic             viol;
      logic             mute;

      assign mute = rf_overdrive_mute[gi];

      // Sign-extend to DW+1 so the full-scale swing (e.g. 0x7FFF -> 0x8000) never overflows.
      always_comb begin
        diff = {sample_i[gi][DW-1], sample_i[gi]} - {prev_q[DW-1], prev_q};
        mag  = diff[DW] ? (~diff + {{DW{1'b0}}, 1'b1}) : diff;
        viol = mag > {1'b0, slew_thresh_i};
      end

      always_comb begin
        run_d = run_q;
        evt_d = 1'b0;
        if (mute) begin
          run_d = 4'd0;
        end else if (s1_vld_q) begin
          if (s1_viol_q) begin
            // A saturated run never re-reaches the target, so each run fires at most once.
            if (run_q != 4'hF) begin
              run_d = run_q + 4'd1;
              evt_d = ((run_q + 4'd1) == run_target);
            end
          end else begin
            run_d = 4'd0;
          end
        end
      end

      always_comb begin
        st_d  = st_q;
        cnt_d = cnt_q;
        if (!mute) begin
          if (evt_q) begin
            st_d = 1'b1;
          end else if (rf_slew_rate_irq_clr[gi]) begin
            st_d = 1'b0;
          end
          if (rf_slew_fault_clr[gi]) begin
            cnt_d = {{(CNT_W-1){1'b0}}, evt_q};
          end else if (evt_q && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          prev_q     <= '0;
          prev_vld_q <= 1'b0;
          s1_vld_q   <= 1'b0;
          s1_viol_q  <= 1'b0;
          run_q      <= 4'd0;
          evt_q      <= 1'b0;
          st_q       <= 1'b0;
          cnt_q      <= '0;
        end else begin
          run_q <= run_d;
          evt_q <= evt_d;
          st_q  <= st_d;
          cnt_q <= cnt_d;
          if (mute) begin
            prev_vld_q <= 1'b0;
            s1_vld_q   <= 1'b0;
            s1_viol_q  <= 1'b0;
          end else begin
            s1_vld_q  <= sample_vld_i[gi] & prev_vld_q;
            s1_viol_q <= sample_vld_i[gi] & prev_vld_q & viol;
            if (sample_vld_i[gi]) begin
              prev_q     <= sample_i[gi];
              prev_vld_q <= 1'b1;
            end
          end
        end
      end

      assign rf_slew_rate_irq[gi]    = st_q;
      assign rf_slew_fault_count[gi] = cnt_q;
    end
  endgenerate

  assign irq_d = |(rf_slew_rate_irq & ~rf_slew_rate_irq_mask);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= irq_d;
    end
  end

  assign irq_o = irq_q;

endmodule
